// File: rtl/ie_defs_pkg.sv
// Shared types and defaults for the OAM sprite-DMA arbiter.
package ie_defs;

  // DMA sequencer states; IDLE leaves the RAM port with the CPU
  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_DUMMY,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'h4014;
  localparam int unsigned OAM_BYTES_DEF    = 256;

endpackage

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares the CPU-side RAM port between cpu_6502 and the
// OAM sprite-DMA engine. A CPU write to DMA_REG_ADDR latches a source page,
// halts the CPU and copies OAM_BYTES bytes {page,idx} from RAM into OAM.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   cpu_*          CPU bus request (addr, write data, write/read strobes)
//   halt           CPU stall request, high whenever the DMA owns the bus
//   dma_busy       high in every non-IDLE state
//   mem_*          muxed RAM port; mem_data_rd is one cycle after address
//   oam_*          OAM write port, one oam_we pulse per byte
module oam_dma_arbiter
  import ie_defs::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter int unsigned OAM_BYTES    = OAM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_mem_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic        halt,
  output logic        dma_busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_wr,
  output logic        mem_write_en,
  input  logic [7:0]  mem_data_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  localparam int unsigned IDX_W = $clog2(OAM_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OAM_BYTES - 1);

  dma_state_t       state_q, state_d;
  logic [7:0]       page_q, page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cyc_odd_q;
  logic             oam_we_d;
  logic [7:0]       oam_addr_d, oam_data_d;
  logic [15:0]      dma_addr;

  // Read strobe is only observed by bus monitors upstream; it never steers the DMA.
  logic unused_read;
  assign unused_read = cpu_read_en;

  // Source address; page is fixed for the whole transfer, idx never carries into it.
  assign dma_addr = 16'({page_q, idx_q});

  assign halt     = (state_q != DMA_IDLE);
  assign dma_busy = (state_q != DMA_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DMA_IDLE;
      page_q    <= 8'h00;
      idx_q     <= '0;
      cyc_odd_q <= 1'b0;
      oam_we    <= 1'b0;
      oam_addr  <= 8'h00;
      oam_data  <= 8'h00;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      cyc_odd_q <= ~cyc_odd_q;
      oam_we    <= oam_we_d;
      oam_addr  <= oam_addr_d;
      oam_data  <= oam_data_d;
    end
  end

  // Next-state and OAM write sequencing
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    oam_we_d   = 1'b0;
    oam_addr_d = oam_addr;
    oam_data_d = oam_data;
    unique case (state_q)
      DMA_IDLE: begin
        if (cpu_write_en && (cpu_mem_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_out;
          idx_d   = '0;
          state_d = DMA_DUMMY;
        end
      end
      // Extra ALIGN cycle only when the next cycle would be odd, so READ lands on even.
      DMA_DUMMY: state_d = cyc_odd_q ? DMA_READ : DMA_ALIGN;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ:  state_d = DMA_WRITE;
      DMA_WRITE: begin
        oam_we_d   = 1'b1;
        oam_addr_d = 8'(idx_q);
        oam_data_d = mem_data_rd;
        if (idx_q == IDX_LAST) begin
          state_d = DMA_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = DMA_READ;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
  end

  // RAM port mux: CPU owns it in IDLE, DMA drives a read-only address otherwise.
  always_comb begin
    mem_addr     = dma_addr;
    mem_data_wr  = 8'h00;
    mem_write_en = 1'b0;
    if (state_q == DMA_IDLE) begin
      mem_addr     = cpu_mem_addr;
      mem_data_wr  = cpu_data_out;
      mem_write_en = cpu_write_en;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a synchronous RAM model and an OAM model.
module tb_oam_dma_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_mem_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        halt;
  logic        dma_busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_wr;
  logic        mem_write_en;
  logic [7:0]  mem_data_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  logic [7:0] ram [0:65535];
  logic [7:0] oam [0:255];
  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  oam_dma_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_mem_addr (cpu_mem_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_write_en (cpu_write_en),
    .cpu_read_en  (cpu_read_en),
    .halt         (halt),
    .dma_busy     (dma_busy),
    .mem_addr     (mem_addr),
    .mem_data_wr  (mem_data_wr),
    .mem_write_en (mem_write_en),
    .mem_data_rd  (mem_data_rd),
    .oam_addr     (oam_addr),
    .oam_data     (oam_data),
    .oam_we       (oam_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: write on edge, read data valid the cycle after the address
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_data_wr;
    mem_data_rd <= ram[mem_addr];
  end

  // OAM keeps its contents across reset
  always @(posedge clk) begin
    if (oam_we) oam[oam_addr] <= oam_data;
  end

  // Cycle index since reset release; cycle 0 is the first (even) cycle
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [7:0] pat(input logic [7:0] page, input logic [7:0] i);
    case (page)
      8'h01:   return i ^ 8'h3C;
      8'h02:   return i ^ 8'hA5;
      8'h03:   return i + 8'h07;
      8'hFF:   return ~i;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_page(input logic [7:0] page);
    for (int i = 0; i < 256; i++) ram[{page, 8'(i)}] = pat(page, 8'(i));
  endtask

  task automatic check_oam(input logic [7:0] page, input int lo, input int hi, input string tag);
    int errs;
    errs = 0;
    for (int i = lo; i <= hi; i++) if (oam[i] !== pat(page, 8'(i))) errs++;
    check(tag, errs, 0);
  endtask

  // Present a $4014 write; par >= 0 first waits for a cycle of that parity
  task automatic fire(input logic [7:0] page, input int par, input string tag);
    if (par >= 0) begin
      @(negedge clk);
      while ((cyc % 2) != par) @(negedge clk);
    end
    cpu_mem_addr = 16'h4014;
    cpu_data_out = page;
    cpu_write_en = 1'b1;
    cpu_read_en  = 1'b0;
    #1;
    check({tag, "_trig_we"}, mem_write_en, 1);
    check({tag, "_trig_addr"}, mem_addr, 16'h4014);
  endtask

  // Follow a transfer until the first IDLE cycle; returns on that cycle's negedge
  task automatic watch(input logic [7:0] page, input int exp_halt, input string tag);
    int halt_cnt, pulses, bad_we, bad_addr, bad_seq, bad_data, bad_busy, first_par;
    bit done;
    halt_cnt = 0; pulses = 0; bad_we = 0; bad_addr = 0; bad_seq = 0;
    bad_data = 0; bad_busy = 0; first_par = -1; done = 0;
    for (int k = 0; k < 1200 && !done; k++) begin
      @(negedge clk);
      // A stray $4014 write mid-transfer must be ignored
      cpu_write_en = (k == 5);
      cpu_mem_addr = (k == 5) ? 16'h4014 : 16'h0000;
      cpu_data_out = (k == 5) ? 8'h77 : 8'h00;
      #1;
      if (oam_we) begin
        if (pulses == 0) first_par = cyc % 2;
        if (oam_addr != 8'(pulses)) bad_seq++;
        if (oam_data !== pat(page, oam_addr)) bad_data++;
        pulses++;
      end
      if (dma_busy != halt) bad_busy++;
      if (!halt) begin
        done = 1;
      end else begin
        halt_cnt++;
        if (mem_write_en) bad_we++;
        if (mem_addr[15:8] != page) bad_addr++;
      end
    end
    cpu_write_en = 1'b0;
    check({tag, "_ended"}, done, 1);
    check({tag, "_halt_len"}, halt_cnt, exp_halt);
    check({tag, "_pulses"}, pulses, 256);
    check({tag, "_mem_we"}, bad_we, 0);
    check({tag, "_src_page"}, bad_addr, 0);
    check({tag, "_oam_seq"}, bad_seq, 0);
    check({tag, "_oam_data"}, bad_data, 0);
    check({tag, "_busy"}, bad_busy, 0);
    check({tag, "_read_par"}, first_par, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    rst          = 1'b1;
    cpu_mem_addr = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_write_en = 1'b0;
    cpu_read_en  = 1'b0;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    load_page(8'h01);
    load_page(8'h02);
    load_page(8'h03);
    load_page(8'hFF);

    // Reset values
    @(negedge clk); @(negedge clk);
    cpu_mem_addr = 16'h1234;
    cpu_data_out = 8'h9A;
    #1;
    check("rst_halt", halt, 0);
    check("rst_busy", dma_busy, 0);
    check("rst_oam_we", oam_we, 0);
    check("rst_oam_addr", oam_addr, 0);
    check("rst_oam_data", oam_data, 0);
    check("rst_mem_addr", mem_addr, 16'h1234);
    check("rst_mem_data", mem_data_wr, 8'h9A);
    @(negedge clk);
    rst = 1'b0;

    // Passthrough: write $4015 and read $4014 never start a DMA
    @(negedge clk);
    cpu_mem_addr = 16'h4015; cpu_data_out = 8'h55; cpu_write_en = 1'b1;
    #1;
    check("pt_w_addr", mem_addr, 16'h4015);
    check("pt_w_data", mem_data_wr, 8'h55);
    check("pt_w_we", mem_write_en, 1);
    @(negedge clk);
    check("pt_w_halt", halt, 0);
    check("pt_w_ram", ram[16'h4015], 8'h55);
    cpu_write_en = 1'b0; cpu_read_en = 1'b1; cpu_mem_addr = 16'h4014;
    #1;
    check("pt_r_addr", mem_addr, 16'h4014);
    check("pt_r_we", mem_write_en, 0);
    check("pt_r_data", mem_data_wr, 8'h55);
    @(negedge clk);
    check("pt_r_halt", halt, 0);
    cpu_read_en = 1'b0;

    // Even-cycle trigger: 513 halted cycles
    fire(8'h02, 0, "even");
    watch(8'h02, 513, "even");
    @(negedge clk);
    check_oam(8'h02, 0, 255, "even_oam");
    check("even_trig_ram", ram[16'h4014], 8'h02);

    // Odd-cycle trigger: extra ALIGN cycle, 514 halted cycles
    fire(8'h01, 1, "odd");
    watch(8'h01, 514, "odd");
    @(negedge clk);
    check_oam(8'h01, 0, 255, "odd_oam");

    // Reset while byte 100's strobe is on the bus
    fire(8'h02, 0, "rst");
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      cpu_write_en = 1'b0;
      #1;
      if (oam_we && oam_addr == 8'd100) found = 1;
    end
    check("rst_reach_byte100", found, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_halt", halt, 0);
    check("rst_mid_busy", dma_busy, 0);
    check("rst_mid_oam_we", oam_we, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check_oam(8'h02, 0, 99, "rst_oam_written");
    check_oam(8'h01, 100, 255, "rst_oam_kept");

    // Fresh transfer after reset release
    fire(8'h03, 1, "post_rst");
    watch(8'h03, 514, "post_rst");
    @(negedge clk);
    check_oam(8'h03, 0, 255, "post_rst_oam");

    // Top page: source stays in 0xFF00..0xFFFF
    fire(8'hFF, 0, "page_ff");
    watch(8'hFF, 513, "page_ff");
    @(negedge clk);
    check_oam(8'hFF, 0, 255, "page_ff_oam");

    // Back-to-back: retrigger in the first IDLE cycle
    fire(8'h01, 0, "b2b_a");
    watch(8'h01, 513, "b2b_a");
    fire(8'h02, -1, "b2b_b");
    watch(8'h02, 513, "b2b_b");
    @(negedge clk);
    check_oam(8'h02, 0, 255, "b2b_oam");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
